// File: rtl/crc_serial_checker.sv
// Serial CRC receiver: deserialises an LSB-first payload, recomputes its Galois LFSR CRC
// and compares it against the LSB-first CRC that follows, pulsing a one-cycle verdict.
module crc_serial_checker #(
    parameter int                 LFSR_WD = 8,
    parameter int                 DATA_WD = 8,
    parameter logic [LFSR_WD-1:0] TAPS    = 8'b10101010
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [LFSR_WD-1:0] Seed,
    input  logic               IN,
    input  logic               Valid,
    input  logic               Abort,
    output logic [DATA_WD-1:0] Data_Out,
    output logic [LFSR_WD-1:0] CRC_Calc,
    output logic               Done,
    output logic               CRC_OK,
    output logic               CRC_ERR,
    output logic               Busy
);

    localparam int MAX_WD = (DATA_WD > LFSR_WD) ? DATA_WD : LFSR_WD;
    localparam int CNT_WD = $clog2(MAX_WD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CRC
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;
    logic [LFSR_WD-1:0]  crc_q, crc_d;
    logic [LFSR_WD-1:0]  rx_q, rx_d;
    logic [DATA_WD-1:0]  data_q, data_d;
    logic [DATA_WD-1:0]  dout_q, dout_d;
    logic [LFSR_WD-1:0]  calc_q, calc_d;
    logic                done_q, done_d;
    logic                ok_q, ok_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [LFSR_WD-1:0]  rx_shift;
    logic [DATA_WD-1:0]  data_shift;

    function automatic logic [LFSR_WD-1:0] crc_step(input logic [LFSR_WD-1:0] c, input logic b);
        logic [LFSR_WD-1:0] n;
        logic               fb;
        fb   = c[LFSR_WD-1] ^ b;
        n[0] = fb;
        for (int i = 1; i < LFSR_WD; i++) begin
            n[i] = TAPS[i] ? (c[i-1] ^ fb) : c[i-1];
        end
        return n;
    endfunction

    // Shift through a one-bit-wider concat so DATA_WD=1 needs no special slicing.
    assign rx_shift   = LFSR_WD'({IN, rx_q} >> 1);
    assign data_shift = DATA_WD'({IN, data_q} >> 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        rx_d    = rx_q;
        data_d  = data_q;
        dout_d  = dout_q;
        calc_d  = calc_q;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;

        if (Abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    crc_d = Seed;
                    cnt_d = '0;
                    if (Valid) begin
                        crc_d  = crc_step(Seed, IN);
                        data_d = data_shift;
                        if (DATA_WD == 1) begin
                            state_d = S_CRC;
                        end else begin
                            cnt_d   = CNT_WD'(1);
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (Valid) begin
                        crc_d  = crc_step(crc_q, IN);
                        data_d = data_shift;
                        if (cnt_q == CNT_WD'(DATA_WD - 1)) begin
                            cnt_d   = '0;
                            state_d = S_CRC;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_CRC: begin
                    if (Valid) begin
                        rx_d = rx_shift;
                        if (cnt_q == CNT_WD'(LFSR_WD - 1)) begin
                            cnt_d   = '0;
                            state_d = S_IDLE;
                            dout_d  = data_q;
                            calc_d  = crc_q;
                            done_d  = 1'b1;
                            ok_d    = (rx_shift == crc_q);
                            err_d   = (rx_shift != crc_q);
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            crc_q   <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            dout_q  <= '0;
            calc_q  <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            calc_q  <= calc_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign Data_Out = dout_q;
    assign CRC_Calc = calc_q;
    assign Done     = done_q;
    assign CRC_OK   = ok_q;
    assign CRC_ERR  = err_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_crc_serial_checker.sv
// Randomised bench for crc_serial_checker: frames are driven bit by bit and every Done is
// checked against a polynomial-arithmetic CRC model held in an expectation queue.
module tb_crc_serial_checker;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] Seed;
    logic       IN;
    logic       Valid;
    logic       Abort;
    logic [7:0] Data_Out;
    logic [7:0] CRC_Calc;
    logic       Done;
    logic       CRC_OK;
    logic       CRC_ERR;
    logic       Busy;

    crc_serial_checker dut (
        .CLK     (CLK),
        .RST     (RST),
        .Seed    (Seed),
        .IN      (IN),
        .Valid   (Valid),
        .Abort   (Abort),
        .Data_Out(Data_Out),
        .CRC_Calc(CRC_Calc),
        .Done    (Done),
        .CRC_OK  (CRC_OK),
        .CRC_ERR (CRC_ERR),
        .Busy    (Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] pay;
        logic [7:0] calc;
        logic       ok;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Payload bits enter LSB-first; each step multiplies by x and reduces by (TAPS | 1).
    function automatic logic [7:0] ref_crc(input logic [7:0] seed, input logic [7:0] pay);
        int c;
        int fb;
        c = seed;
        for (int i = 0; i < 8; i++) begin
            fb = ((c >> 7) & 1) ^ int'(pay[i]);
            c  = ((c << 1) & 'hFF) ^ (fb != 0 ? ('hAA | 1) : 0);
        end
        return 8'(c);
    endfunction

    always @(negedge CLK) begin
        if (!RST) begin
            if (Done) begin
                if (expq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("data_out", 32'(Data_Out), 32'(mon_e.pay));
                    chk("crc_calc", 32'(CRC_Calc), 32'(mon_e.calc));
                    chk("crc_ok",   32'(CRC_OK),   32'(mon_e.ok));
                    chk("crc_err",  32'(CRC_ERR),  32'(!mon_e.ok));
                end
            end else if (CRC_OK || CRC_ERR) begin
                chk("stray_verdict", 32'({CRC_OK, CRC_ERR}), 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        IN    = b;
        Valid = 1'b1;
        @(negedge CLK);
        Valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] seed, input logic [7:0] pay,
                              input logic [7:0] crcv, input int gmax);
        exp_t e;
        e.pay  = pay;
        e.calc = ref_crc(seed, pay);
        e.ok   = (crcv == e.calc);
        expq.push_back(e);
        Seed = seed;
        for (int i = 0; i < 16; i++) begin
            if (i > 0 && gmax > 0) idle($urandom_range(1, gmax));
            send_bit(i < 8 ? pay[i] : crcv[i-8]);
            if (i == 0) begin
                chk("busy_after_first", 32'(Busy), 32'd1);
                Seed = 8'($urandom);
            end
        end
    endtask

    initial begin
        logic [7:0] saved;
        logic [7:0] s;
        logic [7:0] p;
        RST   = 1'b1;
        Seed  = 8'h00;
        IN    = 1'b0;
        Valid = 1'b0;
        Abort = 1'b0;
        idle(3);
        chk("rst_data_out", 32'(Data_Out), 32'd0);
        chk("rst_crc_calc", 32'(CRC_Calc), 32'd0);
        chk("rst_done",     32'(Done),     32'd0);
        chk("rst_ok",       32'(CRC_OK),   32'd0);
        chk("rst_err",      32'(CRC_ERR),  32'd0);
        chk("rst_busy",     32'(Busy),     32'd0);
        RST = 1'b0;
        idle(2);

        send_frame(8'h00, 8'h00, 8'h00, 0);
        chk("t1_done",      32'(Done),     32'd1);
        chk("t1_busy_low",  32'(Busy),     32'd0);

        send_frame(8'h00, 8'h80, 8'hAB, 0);
        chk("t2_crc_calc",  32'(CRC_Calc), 32'hAB);
        chk("t2_ok",        32'(CRC_OK),   32'd1);

        send_frame(8'h00, 8'h80, 8'hA3, 0);
        chk("t3_err",       32'(CRC_ERR),  32'd1);
        chk("t3_crc_calc",  32'(CRC_Calc), 32'hAB);
        idle(3);

        send_frame(8'h00, 8'h80, 8'hAB, 5);
        send_frame(8'h00, 8'h80, 8'hAB, 5);
        send_frame(8'h5A, 8'h3C, ref_crc(8'h5A, 8'h3C), 0);
        idle(2);

        saved = Data_Out;
        Seed  = 8'h00;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        Abort = 1'b1;
        IN    = 1'b1;
        Valid = 1'b1;
        @(negedge CLK);
        Abort = 1'b0;
        Valid = 1'b0;
        chk("abort_busy",   32'(Busy),     32'd0);
        chk("abort_dout",   32'(Data_Out), 32'(saved));
        idle(3);
        chk("abort_dout_hold", 32'(Data_Out), 32'(saved));
        send_frame(8'h00, 8'h00, 8'h00, 0);

        send_frame(8'h00, 8'h80, 8'hAB, 0);
        idle(2);
        Seed = 8'h00;
        for (int i = 0; i < 10; i++) send_bit(i == 7 || i == 8);
        RST = 1'b1;
        #1;
        chk("rst_mid_data_out", 32'(Data_Out), 32'd0);
        chk("rst_mid_crc_calc", 32'(CRC_Calc), 32'd0);
        chk("rst_mid_busy",     32'(Busy),     32'd0);
        chk("rst_mid_done",     32'(Done),     32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        send_frame(8'h00, 8'h80, 8'hAB, 0);

        for (int k = 0; k < 100; k++) begin
            s = 8'($urandom);
            p = 8'($urandom);
            send_frame(s, p, ref_crc(s, p), $urandom_range(0, 2));
        end
        for (int k = 0; k < 20; k++) begin
            s = 8'($urandom);
            p = 8'($urandom);
            send_frame(s, p, ref_crc(s, p) ^ (8'd1 << $urandom_range(0, 7)), 0);
        end

        idle(4);
        chk("pending_frames", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
